// File: rtl/pipe_pkg.sv
// Shared encodings, pipeline payload types and the operand-forwarding helper
// for the pipelined MIPS-32 computer.
package pipe_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                          OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                          OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                          OP_LW    = 6'h23, OP_SW   = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03,
                          FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                          FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                          FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR = 6'h27,
                          FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_e;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [25:0] jaddr;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [4:0]  shamt;
      alu_op_e     alu;
      logic        use_imm;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        is_beq;
      logic        is_bne;
      logic        is_jmp;
      logic        is_jal;
      logic        is_jr;
   } idex_t;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store;
      logic [4:0]  dest;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
   } exmem_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  dest;
      logic        reg_we;
   } memwb_t;

   // Youngest pending write wins; $0 is never forwarded.
   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v,
                                       input exmem_t em, input memwb_t mw);
      if (r != 5'd0 && em.reg_we && em.dest == r) return em.result;
      if (r != 5'd0 && mw.reg_we && mw.dest == r) return mw.data;
      return v;
   endfunction

endpackage

// File: rtl/pipe_cpu.sv
// Five-stage MIPS-32 core: fetch PC, pipeline registers, forwarding,
// load-use interlock and EX-stage redirect with IF/ID + ID/EX flush.
module pipe_cpu
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [31:0] dm_rdata,
   input  logic [4:0]  reg_sel,
   output logic [31:0] PC,
   output logic [31:0] dm_addr_c,
   output logic        dm_we_c,
   output logic [31:0] dm_wdata_c,
   output logic [31:0] reg_data_c
);
   logic [31:0] ifid_instr, ifid_pc4;
   idex_t       id_dec, idex;
   exmem_t      exmem, ex_out;
   memwb_t      memwb, mem_out;
   logic        stall_c, redirect_c;
   logic [31:0] target_c, fwd_a, fwd_b, alu_b, alu_y;

   pipe_id id_stage (
      .clk(clk), .rst(rst), .instr(ifid_instr), .pc4(ifid_pc4), .wb(memwb),
      .dbg_sel(reg_sel), .dec(id_dec), .dbg_data(reg_data_c)
   );

   // Load-use interlock compares the raw rs/rt fields of the decoding word.
   assign stall_c = idex.mem_rd && idex.dest != 5'd0 &&
                    (idex.dest == ifid_instr[25:21] || idex.dest == ifid_instr[20:16]);

   always_comb begin
      fwd_a = fwd(idex.rs, idex.rs_val, exmem, memwb);
      fwd_b = fwd(idex.rt, idex.rt_val, exmem, memwb);
      alu_b = idex.use_imm ? idex.imm : fwd_b;
      alu_y = '0;
      case (idex.alu)
         ALU_ADD:  alu_y = fwd_a + alu_b;
         ALU_SUB:  alu_y = fwd_a - alu_b;
         ALU_AND:  alu_y = fwd_a & alu_b;
         ALU_OR:   alu_y = fwd_a | alu_b;
         ALU_XOR:  alu_y = fwd_a ^ alu_b;
         ALU_NOR:  alu_y = ~(fwd_a | alu_b);
         ALU_SLT:  alu_y = {31'b0, $signed(fwd_a) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'b0, fwd_a < alu_b};
         ALU_SLL:  alu_y = alu_b << idex.shamt;
         ALU_SRL:  alu_y = alu_b >> idex.shamt;
         ALU_SRA:  alu_y = 32'($signed(alu_b) >>> idex.shamt);
         ALU_LUI:  alu_y = {alu_b[15:0], 16'h0000};
         default:  alu_y = '0;
      endcase

      redirect_c = (idex.is_beq && fwd_a == fwd_b) || (idex.is_bne && fwd_a != fwd_b) ||
                   idex.is_jmp || idex.is_jr;
      target_c = idex.pc4 + {idex.imm[29:0], 2'b00};
      if (idex.is_jmp) target_c = {idex.pc4[31:28], idex.jaddr, 2'b00};
      if (idex.is_jr)  target_c = fwd_a;

      ex_out        = '0;
      ex_out.result = idex.is_jal ? idex.pc4 : alu_y;
      ex_out.store  = fwd_b;
      ex_out.dest   = idex.dest;
      ex_out.reg_we = idex.reg_we;
      ex_out.mem_rd = idex.mem_rd;
      ex_out.mem_wr = idex.mem_wr;

      mem_out        = '0;
      mem_out.data   = exmem.mem_rd ? dm_rdata : exmem.result;
      mem_out.dest   = exmem.dest;
      mem_out.reg_we = exmem.reg_we;
   end

   assign dm_addr_c  = exmem.result;
   assign dm_we_c    = exmem.mem_wr;
   assign dm_wdata_c = exmem.store;

   // Redirect outranks a simultaneous load-use stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC         <= RESET_PC;
         ifid_instr <= NOP;
         ifid_pc4   <= '0;
         idex       <= '0;
         exmem      <= '0;
         memwb      <= '0;
      end else begin
         exmem <= ex_out;
         memwb <= mem_out;
         if (redirect_c) begin
            PC         <= target_c;
            ifid_instr <= NOP;
            ifid_pc4   <= '0;
            idex       <= '0;
         end else if (stall_c) begin
            idex <= '0;
         end else begin
            PC         <= PC + 32'd4;
            ifid_instr <= instr;
            ifid_pc4   <= PC + 32'd4;
            idex       <= id_dec;
         end
      end
   end

endmodule

// File: rtl/pipe_dmem.sv
// Word data RAM: combinational read, rising-edge write, cleared by reset.
module pipe_dmem #(
   parameter  int unsigned WORDS = 128,
   localparam int unsigned AW    = $clog2(WORDS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata_c
);
   logic [31:0]   mem [0:WORDS-1];
   logic [AW-1:0] idx;
   logic          unused_addr_bits;

   // Byte offset dropped, upper bits wrap the address space.
   assign idx              = addr[AW+1:2];
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata_c = mem[idx];

endmodule

// File: rtl/pipe_id.sv
// Decode stage: instruction decoder plus the register file.
module pipe_id
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [31:0] pc4,
   input  memwb_t      wb,
   input  logic [4:0]  dbg_sel,
   output idex_t       dec,
   output logic [31:0] dbg_data
);
   logic [5:0]  op, fn;
   logic [31:0] rs_val, rt_val;

   assign op = instr[31:26];
   assign fn = instr[5:0];

   rf_2r1w U_RF (
      .clk(clk), .rst(rst), .ra(instr[25:21]), .rb(instr[20:16]),
      .we(wb.reg_we), .wa(wb.dest), .wd(wb.data),
      .dbg_sel(dbg_sel), .rda(rs_val), .rdb(rt_val), .dbg_data(dbg_data)
   );

   // Unsupported encodings leave every control bit low and retire as NOP.
   always_comb begin
      dec        = '0;
      dec.pc4    = pc4;
      dec.rs_val = rs_val;
      dec.rt_val = rt_val;
      dec.rs     = instr[25:21];
      dec.rt     = instr[20:16];
      dec.shamt  = instr[10:6];
      dec.jaddr  = instr[25:0];
      dec.imm    = {{16{instr[15]}}, instr[15:0]};
      dec.dest   = instr[20:16];
      case (op)
         OP_RTYPE: begin
            dec.dest   = instr[15:11];
            dec.reg_we = 1'b1;
            case (fn)
               FN_ADD, FN_ADDU: dec.alu = ALU_ADD;
               FN_SUB, FN_SUBU: dec.alu = ALU_SUB;
               FN_AND:  dec.alu = ALU_AND;
               FN_OR:   dec.alu = ALU_OR;
               FN_XOR:  dec.alu = ALU_XOR;
               FN_NOR:  dec.alu = ALU_NOR;
               FN_SLT:  dec.alu = ALU_SLT;
               FN_SLTU: dec.alu = ALU_SLTU;
               FN_SLL:  dec.alu = ALU_SLL;
               FN_SRL:  dec.alu = ALU_SRL;
               FN_SRA:  dec.alu = ALU_SRA;
               FN_JR: begin
                  dec.reg_we = 1'b0;
                  dec.is_jr  = 1'b1;
               end
               default: dec.reg_we = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin dec.use_imm = 1'b1; dec.reg_we = 1'b1; end
         OP_SLTI: begin dec.alu = ALU_SLT; dec.use_imm = 1'b1; dec.reg_we = 1'b1; end
         OP_ANDI: begin
            dec.alu = ALU_AND; dec.use_imm = 1'b1; dec.reg_we = 1'b1;
            dec.imm = {16'h0000, instr[15:0]};
         end
         OP_ORI: begin
            dec.alu = ALU_OR; dec.use_imm = 1'b1; dec.reg_we = 1'b1;
            dec.imm = {16'h0000, instr[15:0]};
         end
         OP_XORI: begin
            dec.alu = ALU_XOR; dec.use_imm = 1'b1; dec.reg_we = 1'b1;
            dec.imm = {16'h0000, instr[15:0]};
         end
         OP_LUI:  begin dec.alu = ALU_LUI; dec.use_imm = 1'b1; dec.reg_we = 1'b1; end
         OP_LW:   begin dec.use_imm = 1'b1; dec.reg_we = 1'b1; dec.mem_rd = 1'b1; end
         OP_SW:   begin dec.use_imm = 1'b1; dec.mem_wr = 1'b1; end
         OP_BEQ:  dec.is_beq = 1'b1;
         OP_BNE:  dec.is_bne = 1'b1;
         OP_J:    dec.is_jmp = 1'b1;
         OP_JAL: begin
            dec.is_jmp = 1'b1; dec.is_jal = 1'b1;
            dec.reg_we = 1'b1; dec.dest = 5'd31;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipe_imem.sv
// Word-addressed instruction ROM with a combinational read; the load port
// is a preload hook and is tied off in the computer.
module pipe_imem #(
   parameter  int unsigned WORDS = 128,
   localparam int unsigned AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          load,
   input  logic [AW-1:0] load_idx,
   input  logic [31:0]   load_data,
   input  logic [AW-1:0] idx,
   output logic [31:0]   data_c
);
   logic [31:0] ROM [0:WORDS-1];

   always_ff @(posedge clk) begin
      if (load) ROM[load_idx] <= load_data;
   end

   assign data_c = ROM[idx];

endmodule

// File: rtl/rf_2r1w.sv
// 32x32 register file: two write-through read ports, one write port, debug read.
module rf_2r1w (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra,
   input  logic [4:0]  rb,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  dbg_sel,
   output logic [31:0] rda,
   output logic [31:0] rdb,
   output logic [31:0] dbg_data
);
   logic [31:0] rf [0:31];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (we && wa != 5'd0) begin
         rf[wa] <= wd;
      end
   end

   // A write landing this cycle is visible to the decode-stage reads.
   assign rda      = (ra == 5'd0) ? '0 : (we && wa == ra) ? wd : rf[ra];
   assign rdb      = (rb == 5'd0) ? '0 : (we && wa == rb) ? wd : rf[rb];
   assign dbg_data = (dbg_sel == 5'd0) ? '0 : rf[dbg_sel];

endmodule

// File: rtl/pipecomp.sv
// Pipelined MIPS-32 computer: core, instruction ROM and data RAM on one clock.
// rstn is an active-high asynchronous reset despite its name.
module pipecomp #(
   parameter int unsigned IM_WORDS = 128,
   parameter int unsigned DM_WORDS = 128
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   localparam int unsigned IM_AW = $clog2(IM_WORDS);

   logic [31:0] PC, instr, dm_addr, dm_wdata, dm_rdata;
   logic        dm_we;
   logic        unused_pc_bits;

   // Fetch index wraps modulo the ROM depth.
   assign unused_pc_bits = ^{PC[31:IM_AW+2], PC[1:0]};

   pipe_imem #(.WORDS(IM_WORDS)) U_IM (
      .clk(clk), .load(1'b0), .load_idx('0), .load_data('0),
      .idx(PC[IM_AW+1:2]), .data_c(instr)
   );

   pipe_dmem #(.WORDS(DM_WORDS)) U_DM (
      .clk(clk), .rst(rstn), .we(dm_we), .addr(dm_addr),
      .wdata(dm_wdata), .rdata_c(dm_rdata)
   );

   pipe_cpu U_SCPU (
      .clk(clk), .rst(rstn), .instr(instr), .dm_rdata(dm_rdata), .reg_sel(reg_sel),
      .PC(PC), .dm_addr_c(dm_addr), .dm_we_c(dm_we), .dm_wdata_c(dm_wdata),
      .reg_data_c(reg_data)
   );

endmodule

// File: tb/tb_pipecomp.sv
// Directed program bench for pipecomp: expected register values are queued
// when a program is loaded and popped once the run reaches its stop PC.
module tb_pipecomp;
   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;

   typedef struct {
      string       tag;
      logic [4:0]  r;
      logic [31:0] v;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] prog [$];
   int          compared = 0;
   int          mismatched = 0;
   int          cycles;
   int          stalls;

   always #5 clk = ~clk;

   pipecomp dut (.clk(clk), .rstn(rstn), .reg_sel(reg_sel), .reg_data(reg_data));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_reg(input string tag, input int r, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.r   = 5'(r);
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic load_rom(input logic [31:0] words [$]);
      for (int i = 0; i < 128; i++)
         dut.U_IM.ROM[i] = (i < words.size()) ? words[i] : 32'h0;
   endtask

   // Loads a program under reset and releases on a falling edge.
   task automatic start(input logic [31:0] words [$]);
      rstn = 1'b1;
      load_rom(words);
      repeat (2) @(negedge clk);
      rstn = 1'b0;
   endtask

   task automatic run_until(input logic [31:0] stop, input int budget);
      logic [31:0] prev;
      prev   = dut.PC;
      cycles = 0;
      stalls = 0;
      while (dut.PC !== stop && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (dut.PC === prev) stalls++;
         prev = dut.PC;
      end
      check("reach_stop_pc", dut.PC, stop);
   endtask

   task automatic drain;
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         reg_sel = e.r;
         #1;
         check(e.tag, reg_data, e.v);
      end
   endtask

   initial begin
      rstn    = 1'b1;
      reg_sel = 5'd0;

      // Back-to-back ALU forwarding, also the power-on reset checks
      prog = '{32'h20010005, 32'h20220003, 32'h00221820, 32'h00612022};
      load_rom(prog);
      #12;
      check("reset_pc", dut.PC, 32'h0);
      reg_sel = 5'd1; #1;
      check("reset_reg_data", reg_data, 32'h0);
      expect_reg("fwd_rf1", 1, 32'd5);
      expect_reg("fwd_rf2", 2, 32'd8);
      expect_reg("fwd_rf3", 3, 32'd13);
      expect_reg("fwd_rf4", 4, 32'd8);
      start(prog);
      run_until(32'h80, 200);
      check("fwd_cycles", 32'(cycles), 32'd32);
      check("fwd_stalls", 32'(stalls), 32'd0);
      drain();

      // Load-use stall, interrupted by a mid-run reset
      prog = '{32'h2005002A, 32'hAC050004, 32'h8C060004, 32'h00C63820};
      start(prog);
      repeat (8) @(negedge clk);
      reg_sel = 5'd5; #1;
      check("pre_reset_rf5", reg_data, 32'h2A);
      check("pre_reset_dm1", dut.U_DM.mem[1], 32'h2A);
      #1 rstn = 1'b1;
      #20;
      check("midrun_reset_pc", dut.PC, 32'h0);
      check("midrun_reset_dm1", dut.U_DM.mem[1], 32'h0);
      for (int r = 0; r < 32; r++) begin
         reg_sel = 5'(r);
         #1;
         check($sformatf("midrun_reset_rf%0d", r), reg_data, 32'h0);
      end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("first_fetch_pc", dut.PC, 32'h0);
      check("first_fetch_instr", dut.instr, 32'h2005002A);
      expect_reg("lu_rf5", 5, 32'h2A);
      expect_reg("lu_rf6", 6, 32'h2A);
      expect_reg("lu_rf7", 7, 32'h54);
      run_until(32'h80, 200);
      check("lu_stalls", 32'(stalls), 32'd1);
      check("lu_cycles", 32'(cycles), 32'd33);
      check("lu_dm1", dut.U_DM.mem[1], 32'h2A);
      drain();

      // Taken branch flushes the two younger instructions
      prog = '{32'h10000002, 32'h20080001, 32'h20090001, 32'h200A0007};
      expect_reg("br_rf8", 8, 32'h0);
      expect_reg("br_rf9", 9, 32'h0);
      expect_reg("br_rf10", 10, 32'd7);
      start(prog);
      run_until(32'h80, 200);
      check("br_stalls", 32'(stalls), 32'd0);
      drain();

      // jal 0x20 from 0x10, jr back to 0x14, then j 0x40 out of the loop
      prog = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0C000008, 32'h200D0001,
               32'h08000010, 32'h0, 32'h200B0009, 32'h03E00008};
      expect_reg("jal_rf31", 31, 32'h14);
      expect_reg("jal_rf11", 11, 32'd9);
      expect_reg("jr_return_rf13", 13, 32'd1);
      expect_reg("jal_rf1_cleared", 1, 32'h0);
      start(prog);
      run_until(32'h80, 300);
      drain();

      // $0 write ignored, lui/ori, sra/slt/sltu and zero-extended andi
      prog = '{32'h20000005, 32'h3C0C1234, 32'h358C5678, 32'h200EFFF8,
               32'h000E7843, 32'h01C0802A, 32'h01C0882B, 32'h31D2FFFF};
      expect_reg("zero_rf0", 0, 32'h0);
      expect_reg("lui_ori_rf12", 12, 32'h12345678);
      expect_reg("addi_neg_rf14", 14, 32'hFFFFFFF8);
      expect_reg("sra_rf15", 15, 32'hFFFFFFFC);
      expect_reg("slt_rf16", 16, 32'd1);
      expect_reg("sltu_rf17", 17, 32'd0);
      expect_reg("andi_zext_rf18", 18, 32'h0000FFF8);
      start(prog);
      run_until(32'h80, 200);
      check("rf0_array", dut.U_SCPU.id_stage.U_RF.rf[0], 32'h0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
